memory_stage: RTL

- Memory stage directly downstream of execute.
- Takes execute's final ALU result as the data address, plus the store data and the read/write controls from decode.
- Runs one access at a time to data memory over a req/ready handshake, and stalls the pipeline until the access finishes.
- Also detects unaligned and illegal accesses, memory timeouts, and halt.

---
 rtl/memory_stage_if.sv | 27 ++
 rtl/memory_stage.sv | 131 +++++++++++++
 2 files changed

// File: rtl/memory_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | memory_stage_if                                                   |
// | Data-memory request/response bus between memory_stage and memory. |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
interface memory_stage_if;
  logic        memReq;
  logic        memWr;
  logic [15:0] memAddr;
  logic [15:0] memDataOut;
  logic        memReady;
  logic [15:0] memDataIn;

  // Pipeline side issues requests
  modport master (
    output memReq, memWr, memAddr, memDataOut,
    input  memReady, memDataIn
  );

  // Memory side answers them
  modport slave (
    input  memReq, memWr, memAddr, memDataOut,
    output memReady, memDataIn
  );
endinterface
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | memory_stage                                                      |
// | Pipeline memory stage: one load/store at a time over a req/ready |
// | handshake, stalls upstream, flags unaligned/illegal accesses,    |
// | memory timeouts and halt.                                         |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module memory_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           aluResult_i,
  input  logic [15:0]           writeData_i,
  input  logic                  memRead_i,
  input  logic                  memWrite_i,
  input  logic                  halt_i,
  memory_stage_if.master        mem,
  output logic [15:0]           readData_o,
  output logic                  stall_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  halted_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BUSY = 3'd1,
    S_DONE = 3'd2,
    S_ERR  = 3'd3,
    S_HALT = 3'd4
  } state_t;

  // Counter value at which the current BUSY cycle is the last one allowed
  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;
  logic        req_q, done_q, err_q, halted_q;
  logic        w_valid;

  // Exactly one of load/store makes a usable access
  assign w_valid = memRead_i ^ memWrite_i;

  // Next-state, datapath capture and combinational stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (halt_i) begin
          state_d = S_HALT;
        end else if (memRead_i && memWrite_i) begin
          state_d = S_ERR;
        end else if (w_valid && aluResult_i[0]) begin
          state_d = S_ERR;
        end else if (w_valid) begin
          stall_o = 1'b1;
          addr_d  = aluResult_i;
          wdata_d = writeData_i;
          wr_d    = memWrite_i;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (mem.memReady) begin
          state_d = S_DONE;
          if (!wr_q) rdata_d = mem.memDataIn;
        end else if (cnt_q == C_TO_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR:  stall_o = 1'b1;
      S_HALT: stall_o = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; status outputs registered from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      wr_q     <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wr_q     <= wr_d;
      req_q    <= (state_d == S_BUSY);
      done_q   <= (state_d == S_DONE);
      err_q    <= (state_d == S_ERR);
      halted_q <= (state_d == S_HALT);
    end
  end

  assign mem.memReq     = req_q;
  assign mem.memWr      = wr_q;
  assign mem.memAddr    = addr_q;
  assign mem.memDataOut = wdata_q;
  assign readData_o     = rdata_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign halted_o       = halted_q;

endmodule
`default_nettype wire
